// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package disp_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned ANODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_DASH  = 4'd10;
    localparam logic [CODE_W-1:0] CODE_R     = 4'd11;
    localparam logic [CODE_W-1:0] CODE_E     = 4'd14;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

    localparam logic [0:SEG_W-1]   SEG_BLANK = 7'b1111111;
    localparam logic [ANODE_W-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/disp_scan_controller_if.sv
// Value-load handshake and display outputs between the calculator core and the scanner.
interface disp_scan_controller_if;
    logic        load;
    logic [15:0] digits_in;
    logic        pending;
    logic        frame_tick;
    logic [1:0]  digit_sel;
    logic [0:6]  segments;
    logic [3:0]  anode_active;

    modport master (
        output load, digits_in,
        input  pending, frame_tick, digit_sel, segments, anode_active
    );

    modport slave (
        input  load, digits_in,
        output pending, frame_tick, digit_sel, segments, anode_active
    );
endinterface

// File: rtl/seg_code_decoder.sv
// Combinational 4-bit display code to active-low a..g segment pattern.
module seg_code_decoder
    import disp_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [0:SEG_W-1]  o_segments_c
);

    // Glyph lookup; every unlisted code is blank
    always_comb begin
        o_segments_c = SEG_BLANK;
        case (i_code)
            4'd0:      o_segments_c = 7'b0000001;
            4'd1:      o_segments_c = 7'b1001111;
            4'd2:      o_segments_c = 7'b0010010;
            4'd3:      o_segments_c = 7'b0000110;
            4'd4:      o_segments_c = 7'b1001100;
            4'd5:      o_segments_c = 7'b0100100;
            4'd6:      o_segments_c = 7'b0100000;
            4'd7:      o_segments_c = 7'b0001111;
            4'd8:      o_segments_c = 7'b0000000;
            4'd9:      o_segments_c = 7'b0000100;
            CODE_DASH: o_segments_c = 7'b1111110;
            CODE_R:    o_segments_c = 7'b1111010;
            CODE_E:    o_segments_c = 7'b0110000;
            default:   o_segments_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_controller.sv
// Four-digit seven-segment scanner with frame-aligned value commit.
// Optional: define DISP_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module disp_scan_controller
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
)(
    input  logic                   clk,
    input  logic                   rst,
    disp_scan_controller_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    scan_state_e        r_state;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_digit_sel;
    logic [15:0]        r_active;
    logic [15:0]        r_shadow;
    logic               r_pending;
    logic               r_frame_tick;
    logic [0:SEG_W-1]   r_segments;
    logic [ANODE_W-1:0] r_anode;

    scan_state_e        w_state_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [1:0]         w_digit_nxt;
    logic               w_slot_end;
    logic               w_wrap;
    logic [CODE_W-1:0]  w_code;
    logic [CODE_W-1:0]  w_code_eff;
    logic [0:SEG_W-1]   w_seg_dec;
    logic [0:SEG_W-1]   w_seg_nxt;
    logic [ANODE_W-1:0] w_anode_nxt;

    // Pick the active-register code for the digit in its slot
    always_comb begin
        w_code = r_active[3:0];
        case (r_digit_sel)
            2'd0:    w_code = r_active[15:12];
            2'd1:    w_code = r_active[11:8];
            2'd2:    w_code = r_active[7:4];
            default: w_code = r_active[3:0];
        endcase
    end

`ifdef DISP_LEAD_ZERO_BLANK_EN
    logic [2:0] w_lead_zero;

    // Leading zeros from the left blank out; the rightmost digit always shows
    always_comb begin
        w_lead_zero[0] = (r_active[15:12] == 4'd0);
        w_lead_zero[1] = w_lead_zero[0] && (r_active[11:8] == 4'd0);
        w_lead_zero[2] = w_lead_zero[1] && (r_active[7:4] == 4'd0);
        w_code_eff     = w_code;
        if (r_digit_sel != 2'd3 && w_lead_zero[r_digit_sel]) begin
            w_code_eff = CODE_BLANK;
        end
    end
`else
    // Every digit decodes literally
    always_comb begin
        w_code_eff = w_code;
    end
`endif

    seg_code_decoder u_dec (
        .i_code       (w_code_eff),
        .o_segments_c (w_seg_dec)
    );

    // Next slot position, next state and next display outputs
    always_comb begin
        w_slot_end  = (r_count == CNT_W'(SCAN_DIV - 1));
        w_wrap      = w_slot_end && (r_digit_sel == 2'd3);
        w_count_nxt = r_count + CNT_W'(1);
        w_digit_nxt = r_digit_sel;
        w_seg_nxt   = SEG_BLANK;
        w_anode_nxt = ANODE_OFF;
        if (w_slot_end) begin
            w_count_nxt = '0;
            w_digit_nxt = r_digit_sel + 2'd1;
        end
        w_state_nxt = (w_count_nxt < CNT_W'(BLANK_CYC)) ? S_BLANK : S_SHOW;
        if (r_state == S_SHOW) begin
            w_anode_nxt = ~(4'b1000 >> r_digit_sel);
            w_seg_nxt   = w_seg_dec;
        end
    end

    // Scan state, slot counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BLANK;
            r_count     <= '0;
            r_digit_sel <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_digit_sel <= w_digit_nxt;
        end
    end

    // Shadow/active registers: commit on frame wrap, a same-cycle load lands after it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= 16'hFFFF;
            r_shadow     <= 16'hFFFF;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;
            if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (bus.load) begin
                r_shadow  <= bus.digits_in;
                r_pending <= 1'b1;
            end
        end
    end

    // Registered segment and anode drive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_segments <= SEG_BLANK;
            r_anode    <= ANODE_OFF;
        end else begin
            r_segments <= w_seg_nxt;
            r_anode    <= w_anode_nxt;
        end
    end

    assign bus.pending      = r_pending;
    assign bus.frame_tick   = r_frame_tick;
    assign bus.digit_sel    = r_digit_sel;
    assign bus.segments     = r_segments;
    assign bus.anode_active = r_anode;

endmodule
